// File: rtl/msg_pkg.sv
// Shared constants and state encoding for the message-store loader.
// Contents: frame marker, frame geometry, byte/word widths, default
// inter-byte timeout and the loader FSM state type.
package msg_pkg;

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int unsigned NUM_WORDS   = 32;
  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned TIMEOUT_DEF = 1000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

endpackage

// File: rtl/msg_word_asm.sv
// Byte-to-word assembler: shifts bytes in big-endian order and flags each
// completed 32-bit word.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clear        restart at byte 0 of a word (new frame)
//   shift        accept byte_in into the word
//   byte_in      incoming byte
//   word_done    1-cycle pulse, the cycle after the 4th byte of a word
//   word         assembled word, first byte in [31:24]; valid with word_done
//   last_byte_c  next shifted byte completes the current word
module msg_word_asm
  import msg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_done,
  output logic [WORD_W-1:0] word,
  output logic              last_byte_c
);

  logic [1:0]        cnt_q;
  logic [WORD_W-1:0] word_q;
  logic              done_q;

  // Shift register and byte-in-word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      word_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        cnt_q <= 2'd0;
      end else if (shift) begin
        word_q <= {word_q[WORD_W-BYTE_W-1:0], byte_in};
        cnt_q  <= cnt_q + 2'd1;
        done_q <= (cnt_q == 2'd3);
      end
    end
  end

  assign last_byte_c = (cnt_q == 2'd3);
  assign word_done   = done_q;
  assign word        = word_q;

endmodule

// File: rtl/msg_loader.sv
// Writer side of the 32x32-bit message store. Frames a host byte stream
// (SYNC, 128 payload bytes, XOR checksum), writes assembled words to the
// store and reports commit or error once the frame ends.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   in_data      host byte; in_valid qualifies it
//   in_ready     byte accepted when in_valid & in_ready
//   hold         store being read; stalls intake
//   wr_en        store write strobe, with wr_addr / wr_data
//   msg_commit   1-cycle pulse: full frame, checksum good
//   msg_error    1-cycle pulse: checksum bad or inter-byte timeout
//   busy         frame in progress
module msg_loader
  import msg_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              msg_commit,
  output logic              msg_error,
  output logic              busy
);

  localparam int unsigned       TMR_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [BYTE_W-1:0]   csum_q, csum_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                busy_q, busy_d;
  logic                commit_q, commit_d;
  logic                error_q, error_d;
  logic                rdy_q;

  logic                xfer_c;
  logic                clear_c;
  logic                shift_c;
  logic                word_done;
  logic [WORD_W-1:0]   word;
  logic                last_byte_c;

  // rdy_q rises on the first clock after reset release, so intake never
  // starts in the cycle reset is removed
  assign in_ready = rdy_q & ~hold;
  assign xfer_c   = in_valid & in_ready;

  msg_word_asm u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear_c),
    .shift       (shift_c),
    .byte_in     (in_data),
    .word_done   (word_done),
    .word        (word),
    .last_byte_c (last_byte_c)
  );

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      csum_q     <= '0;
      timer_q    <= '0;
      busy_q     <= 1'b0;
      commit_q   <= 1'b0;
      error_q    <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      csum_q     <= csum_d;
      timer_q    <= timer_d;
      busy_q     <= busy_d;
      commit_q   <= commit_d;
      error_q    <= error_d;
      rdy_q      <= 1'b1;
    end
  end

  // Next-state, checksum, timer and pulse logic
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    csum_d     = csum_q;
    timer_d    = timer_q;
    busy_d     = busy_q;
    commit_d   = 1'b0;
    error_d    = 1'b0;
    clear_c    = 1'b0;
    shift_c    = 1'b0;

    // Address advances after each write; held at the last word so it never wraps
    if (word_done && (word_idx_q != LAST_WORD)) begin
      word_idx_d = word_idx_q + ADDR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (xfer_c && (in_data == SYNC_BYTE)) begin
          state_d    = PAYLOAD;
          busy_d     = 1'b1;
          csum_d     = '0;
          word_idx_d = '0;
          timer_d    = '0;
          clear_c    = 1'b1;
        end
      end

      PAYLOAD: begin
        if (xfer_c) begin
          shift_c = 1'b1;
          csum_d  = csum_q ^ in_data;
          timer_d = '0;
          if (last_byte_c && (word_idx_q == LAST_WORD)) begin
            state_d = CHECK;
          end
        end else if (timer_q == TMR_MAX) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      CHECK: begin
        if (xfer_c) begin
          commit_d = (in_data == csum_q);
          error_d  = (in_data != csum_q);
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (timer_q == TMR_MAX) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign wr_en      = word_done;
  assign wr_addr    = word_idx_q;
  assign wr_data    = word;
  assign msg_commit = commit_q;
  assign msg_error  = error_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_msg_loader.sv
// Self-checking bench for msg_loader: directed frames plus randomized frames,
// timing and hold pulses, compared against a frame-level reference model.
module tb_msg_loader;

  localparam int unsigned TO   = 16;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        hold;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        msg_commit;
  logic        msg_error;
  logic        busy;

  msg_loader #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .hold       (hold),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .msg_commit (msg_commit),
    .msg_error  (msg_error),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame parser driven by the bench's own view of transfers
  bit          m_rdy, m_took;
  int          m_mode;   // 0 waiting for sync, 1 collecting payload, 2 waiting for checksum
  int          m_nb, m_tmr;
  logic [7:0]  m_csum;
  logic [7:0]  m_frame [128];
  logic        e_wr_en, e_commit, e_error, e_busy;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  always @(posedge clk or negedge rst_n) begin
    bit x;
    if (!rst_n) begin
      m_rdy <= 0; m_took <= 0; m_mode <= 0; m_nb <= 0; m_tmr <= 0; m_csum <= 0;
      e_wr_en <= 0; e_commit <= 0; e_error <= 0; e_busy <= 0; e_addr <= 0; e_data <= 0;
    end else begin
      x = in_valid && !hold && m_rdy;
      m_rdy    <= 1;
      m_took   <= x;
      e_wr_en  <= 0;
      e_commit <= 0;
      e_error  <= 0;
      if (m_mode == 0) begin
        if (x && in_data == SYNC) begin
          m_mode <= 1; m_nb <= 0; m_csum <= 0; m_tmr <= 0; e_busy <= 1;
        end
      end else if (x) begin
        m_tmr <= 0;
        if (m_mode == 1) begin
          m_frame[m_nb] <= in_data;
          m_csum <= m_csum ^ in_data;
          m_nb   <= m_nb + 1;
          if (m_nb % 4 == 3) begin
            e_wr_en <= 1;
            e_addr  <= 5'(m_nb / 4);
            e_data  <= {m_frame[m_nb-3], m_frame[m_nb-2], m_frame[m_nb-1], in_data};
          end
          if (m_nb == 127) m_mode <= 2;
        end else begin
          if (in_data == m_csum) e_commit <= 1; else e_error <= 1;
          e_busy <= 0; m_mode <= 0;
        end
      end else if (m_tmr == TO - 1) begin
        e_error <= 1; e_busy <= 0; m_mode <= 0;
      end else begin
        m_tmr <= m_tmr + 1;
      end
    end
  end

  // Per-cycle comparison and observed message store
  logic [31:0] mem [32];
  int n_wr = 0, n_commit = 0, n_error = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 32'(in_ready), 32'(!hold && m_rdy));
      check("wr_en", 32'(wr_en), 32'(e_wr_en));
      check("msg_commit", 32'(msg_commit), 32'(e_commit));
      check("msg_error", 32'(msg_error), 32'(e_error));
      check("busy", 32'(busy), 32'(e_busy));
      check("pulse_overlap", 32'((32'(wr_en) + 32'(msg_commit) + 32'(msg_error)) > 1), 32'd0);
      if (wr_en && e_wr_en) begin
        check("wr_addr", 32'(wr_addr), 32'(e_addr));
        check("wr_data", wr_data, e_data);
      end
      if (wr_en) begin mem[wr_addr] = wr_data; n_wr++; end
      if (msg_commit) n_commit++;
      if (msg_error) n_error++;
    end
  end

  // Stimulus
  logic [7:0] pl [128];
  bit rand_t = 0;

  task automatic send_byte(input logic [7:0] b);
    int k;
    if (rand_t && $urandom_range(0, 7) == 0) begin
      hold = 1; in_valid = 1; in_data = b;
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      hold = 0;
    end
    in_valid = 1; in_data = b;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!m_took && k < 100);
    if (!m_took) check("xfer_timeout", 32'(k), 32'd0);
    in_valid = 0;
    if (rand_t) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] flip, input int hold_at, input int hold_len);
    logic [7:0] cs;
    int w0;
    cs = 0;
    for (int i = 0; i < 128; i++) cs ^= pl[i];
    send_byte(SYNC);
    for (int i = 0; i < 128; i++) begin
      if (i == hold_at) begin
        w0 = n_wr;
        hold = 1; in_valid = 1; in_data = pl[i];
        repeat (hold_len) begin @(posedge clk); #1; end
        check("hold_no_write", 32'(n_wr - w0), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        hold = 0;
      end
      send_byte(pl[i]);
    end
    send_byte(cs ^ flip);
  endtask

  task automatic check_outcome(input int c0, input int e0, input int w0, input bit good);
    repeat (2) @(negedge clk);
    #1;
    check("commit_cnt", 32'(n_commit - c0), 32'(good));
    check("error_cnt", 32'(n_error - e0), 32'(!good));
    check("write_cnt", 32'(n_wr - w0), 32'd32);
    check("busy_after", 32'(busy), 32'd0);
    for (int w = 0; w < 32; w++)
      check("store_word", mem[w], {pl[4*w], pl[4*w+1], pl[4*w+2], pl[4*w+3]});
  endtask

  task automatic rand_payload();
    for (int i = 0; i < 128; i++) pl[i] = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, e0, w0, k;
    rst_n = 0; in_valid = 0; in_data = 0; hold = 0;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_commit", 32'(msg_commit), 32'd0);
    check("rst_error", 32'(msg_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    #1 check("ready_before_clk", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_clk", 32'(in_ready), 32'd1);

    // Counting payload, good checksum
    for (int i = 0; i < 128; i++) pl[i] = 8'(i);
    c0 = n_commit; e0 = n_error; w0 = n_wr;
    send_frame(8'h00, -1, 0);
    check_outcome(c0, e0, w0, 1);
    check("t1_word0", mem[0], 32'h00010203);
    check("t1_word31", mem[31], 32'h7C7D7E7F);

    // Same frame, checksum off by one bit
    c0 = n_commit; e0 = n_error; w0 = n_wr;
    send_frame(8'h01, -1, 0);
    check_outcome(c0, e0, w0, 0);

    // Junk before the marker is dropped
    rand_payload();
    c0 = n_commit; e0 = n_error; w0 = n_wr;
    send_byte(8'h11); send_byte(8'h22);
    send_frame(8'h00, -1, 0);
    check_outcome(c0, e0, w0, 1);

    // Short hold mid-word with a pending byte
    rand_payload();
    c0 = n_commit; e0 = n_error; w0 = n_wr;
    send_frame(8'h00, 6, 12);
    check_outcome(c0, e0, w0, 1);

    // Long hold runs the inter-byte timer out
    c0 = n_commit; e0 = n_error;
    send_byte(SYNC);
    for (int i = 0; i < 9; i++) send_byte(8'(i + 1));
    hold = 1; in_valid = 1; in_data = 8'h3C;
    repeat (50) begin @(posedge clk); #1; end
    in_valid = 0; hold = 0;
    @(posedge clk); #1;
    check("hold50_error", 32'(n_error - e0), 32'd1);
    check("hold50_commit", 32'(n_commit - c0), 32'd0);
    check("hold50_busy", 32'(busy), 32'd0);

    // Idle timeout after 10 payload bytes, measured from the last transfer
    c0 = n_commit; e0 = n_error;
    send_byte(SYNC);
    for (int i = 0; i < 10; i++) send_byte(8'(i * 7));
    k = 0;
    while (k < 40 && !msg_error) begin @(posedge clk); #1; k++; end
    check("timeout_cycles", 32'(k), 32'(TO));
    @(posedge clk); #1;
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_commit", 32'(n_commit - c0), 32'd0);
    rand_payload();
    c0 = n_commit; e0 = n_error; w0 = n_wr;
    send_frame(8'h00, -1, 0);
    check_outcome(c0, e0, w0, 1);

    // Reset in the middle of a payload
    c0 = n_commit; e0 = n_error;
    send_byte(SYNC);
    for (int i = 0; i < 21; i++) send_byte(8'($urandom));
    rst_n = 0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_wr_data", wr_data, 32'd0);
    check("mid_rst_commit", 32'(msg_commit), 32'd0);
    check("mid_rst_error", 32'(msg_error), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (20) @(posedge clk);
    #1;
    check("mid_rst_no_commit", 32'(n_commit - c0), 32'd0);
    check("mid_rst_no_error", 32'(n_error - e0), 32'd0);
    rand_payload();
    c0 = n_commit; e0 = n_error; w0 = n_wr;
    send_frame(8'h00, -1, 0);
    check_outcome(c0, e0, w0, 1);

    // Randomized frames with random gaps, holds and checksum corruption
    rand_t = 1;
    for (int f = 0; f < 6; f++) begin
      logic [7:0] flip;
      rand_payload();
      flip = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      c0 = n_commit; e0 = n_error; w0 = n_wr;
      send_frame(flip, -1, 0);
      check_outcome(c0, e0, w0, flip == 8'h00);
    end
    rand_t = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
